// File: rtl/div_seq_param_if.sv
// Handshake bundle for the sequential divider: start request with operands
// going in, registered quotient/remainder and status flags coming back.
interface div_seq_param_if #(
   parameter int WIDTH = 32
);
   logic             en;
   logic             sign_mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             valid;
   logic             busy;
   logic             div_zero;
   logic             ovf;

   modport master (
      output en, sign_mode, a, b,
      input  quo, rem, valid, busy, div_zero, ovf
   );

   modport slave (
      input  en, sign_mode, a, b,
      output quo, rem, valid, busy, div_zero, ovf
   );
endinterface

// File: rtl/div_seq_param.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// A request is latched in IDLE, WIDTH restoring steps run in CALC and the
// signs are applied in FIX, giving a fixed latency of WIDTH+1 clocks.
// Optional feature macro: DIV_SIGNED_EN compiles in two's-complement
// support (operand magnitudes, result negation, overflow flag). Without it
// the datapath is unsigned-only and sign_mode is ignored.
module div_seq_param #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   div_seq_param_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvsr;
   logic             zero_r;
   logic             ovf_r;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             ovf_det;
   logic [WIDTH-1:0] fix_quo;
   logic [WIDTH-1:0] fix_rem;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             ge;

`ifdef DIV_SIGNED_EN
   logic sign_a;
   logic sign_b;
   logic neg_q;
   logic neg_r;

   assign sign_a  = bus.sign_mode & bus.a[WIDTH-1];
   assign sign_b  = bus.sign_mode & bus.b[WIDTH-1];
   assign a_mag   = sign_a ? (~bus.a + 1'b1) : bus.a;
   assign b_mag   = sign_b ? (~bus.b + 1'b1) : bus.b;
   assign ovf_det = bus.sign_mode & (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.b);
   assign fix_quo = neg_q ? (~quo_r + 1'b1) : quo_r;
   assign fix_rem = neg_r ? (~rem_r + 1'b1) : rem_r;

   // Remember result signs at load; a zero divisor keeps the all-ones quotient
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == IDLE && bus.en) begin
         neg_q <= (sign_a ^ sign_b) & (|bus.b);
         neg_r <= sign_a;
      end
   end
`else
   logic unused_sign_mode;

   assign unused_sign_mode = bus.sign_mode;
   assign a_mag            = bus.a;
   assign b_mag            = bus.b;
   assign ovf_det          = 1'b0;
   assign fix_quo          = quo_r;
   assign fix_rem          = rem_r;
`endif

   assign shifted  = {rem_r, quo_r[WIDTH-1]};
   assign trial    = shifted - {1'b0, dvsr};
   assign ge       = ~trial[WIDTH] | zero_r;
   assign bus.busy = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: accept in IDLE, count through CALC, one FIX cycle
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.en) state_next = CALC;
         CALC:    if (cnt == '0) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand load, restoring steps and registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         rem_r        <= '0;
         quo_r        <= '0;
         dvsr         <= '0;
         zero_r       <= 1'b0;
         ovf_r        <= 1'b0;
         bus.quo      <= '0;
         bus.rem      <= '0;
         bus.valid    <= 1'b0;
         bus.div_zero <= 1'b0;
         bus.ovf      <= 1'b0;
      end else begin
         bus.valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en) begin
                  rem_r  <= '0;
                  quo_r  <= a_mag;
                  dvsr   <= b_mag;
                  cnt    <= CW'(WIDTH - 1);
                  zero_r <= (bus.b == '0);
                  ovf_r  <= ovf_det;
               end
            end
            CALC: begin
               rem_r <= ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
               quo_r <= {quo_r[WIDTH-2:0], ge};
               cnt   <= cnt - 1'b1;
            end
            FIX: begin
               bus.quo      <= fix_quo;
               bus.rem      <= fix_rem;
               bus.div_zero <= zero_r;
               bus.ovf      <= ovf_r;
               bus.valid    <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param: expected results are queued when a
// request is driven and compared when the divider raises valid.
module tb_div_seq_param;
   localparam int WIDTH   = 32;
   localparam int LATENCY = WIDTH + 1;

   typedef struct packed {
      logic [31:0] quo;
      logic [31:0] rem;
      logic        dz;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   compare_count  = 0;
   int   mismatch_count = 0;
   int   cycle          = 0;
   int   start_cycle    = 0;
   exp_t sb[$];

   div_seq_param_if #(.WIDTH(WIDTH)) bus_i ();

   div_seq_param #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Free-running cycle count used for latency measurement
   always @(posedge clk) cycle <= cycle + 1;

   // Hard stop in case the run wedges somewhere unforeseen
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r,
                               input logic dz, input logic ovf);
      exp_t e;
      e.quo = q;
      e.rem = r;
      e.dz  = dz;
      e.ovf = ovf;
      return e;
   endfunction

   // Behavioural reference divider
   function automatic exp_t model_of(input logic [31:0] a, input logic [31:0] b,
                                     input logic sm);
      exp_t e;
      logic sme;
      int   sa;
      int   sbv;
`ifdef DIV_SIGNED_EN
      sme = sm;
`else
      sme = 1'b0;
      if (sm) sme = 1'b0;
`endif
      sa  = a;
      sbv = b;
      e   = mk(32'h0, 32'h0, 1'b0, 1'b0);
      if (b == 32'h0) begin
         e = mk(32'hFFFF_FFFF, a, 1'b1, 1'b0);
      end else if (sme && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e = mk(32'h8000_0000, 32'h0, 1'b0, 1'b1);
      end else if (sme) begin
         e.quo = sa / sbv;
         e.rem = sa % sbv;
      end else begin
         e.quo = a / b;
         e.rem = a % b;
      end
      return e;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
      compare_count++;
      if (actual !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Called at a negedge; drives one start request and queues its expectation
   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic sm, input exp_t e);
      bus_i.en        = 1'b1;
      bus_i.a         = a;
      bus_i.b         = b;
      bus_i.sign_mode = sm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start_cycle = cycle;
      bus_i.en    = 1'b0;
      @(negedge clk);
      check_output("busy after accept", bus_i.busy, 1'b1);
      check_output("valid low after accept", bus_i.valid, 1'b0);
   endtask

   // Waits (bounded) for valid and compares against the scoreboard head
   task automatic wait_result(input string tag);
      bit   seen = 1'b0;
      exp_t e;
      for (int k = 0; k < LATENCY + 10 && !seen; k++) begin
         @(negedge clk);
         if (bus_i.valid) seen = 1'b1;
      end
      check_output({tag, " valid seen"}, seen, 1'b1);
      if (sb.size() == 0) begin
         check_output({tag, " scoreboard entry"}, 0, 1);
      end else begin
         e = sb.pop_front();
         if (seen) begin
            check_output({tag, " latency"}, cycle - start_cycle, LATENCY);
            check_output({tag, " busy in valid cycle"}, bus_i.busy, 1'b0);
            check_output({tag, " quo"}, bus_i.quo, e.quo);
            check_output({tag, " rem"}, bus_i.rem, e.rem);
            check_output({tag, " div_zero"}, bus_i.div_zero, e.dz);
            check_output({tag, " ovf"}, bus_i.ovf, e.ovf);
         end
      end
   endtask

   initial begin
      exp_t e;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      int          vcount;

      rst_n           = 1'b0;
      bus_i.en        = 1'b0;
      bus_i.a         = '0;
      bus_i.b         = '0;
      bus_i.sign_mode = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset quo", bus_i.quo, 32'h0);
      check_output("reset rem", bus_i.rem, 32'h0);
      check_output("reset valid", bus_i.valid, 1'b0);
      check_output("reset busy", bus_i.busy, 1'b0);
      check_output("reset div_zero", bus_i.div_zero, 1'b0);
      check_output("reset ovf", bus_i.ovf, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      apply_stimulus(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0, 1'b0));
      wait_result("u 100/7");
      @(negedge clk);
      check_output("valid single pulse", bus_i.valid, 1'b0);

`ifdef DIV_SIGNED_EN
      e = mk(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
`else
      e = model_of(32'hFFFF_FF9C, 32'd7, 1'b1);
`endif
      apply_stimulus(32'hFFFF_FF9C, 32'd7, 1'b1, e);
      wait_result("s -100/7");

`ifdef DIV_SIGNED_EN
      e = mk(32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
`else
      e = model_of(32'd100, 32'hFFFF_FFF9, 1'b1);
`endif
      apply_stimulus(32'd100, 32'hFFFF_FFF9, 1'b1, e);
      wait_result("s 100/-7");

`ifdef DIV_SIGNED_EN
      e = mk(32'h8000_0000, 32'h0, 1'b0, 1'b1);
`else
      e = mk(32'h0, 32'h8000_0000, 1'b0, 1'b0);
`endif
      apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e);
      wait_result("s min/-1");

      apply_stimulus(32'h1234, 32'h0, 1'b0, mk(32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0));
      wait_result("u div zero");
      apply_stimulus(32'h1234, 32'h0, 1'b1, mk(32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0));
      wait_result("s div zero");

      // Request during busy must be dropped
      apply_stimulus(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0, 1'b0));
      repeat (4) @(negedge clk);
      bus_i.en = 1'b1;
      bus_i.a  = 32'd50;
      bus_i.b  = 32'd3;
      @(posedge clk);
      #1;
      bus_i.en = 1'b0;
      wait_result("ignored en");

      // Request in the valid cycle is accepted back to back
      apply_stimulus(32'd50, 32'd3, 1'b0, mk(32'd16, 32'd2, 1'b0, 1'b0));
      wait_result("b2b 50/3");
      @(negedge clk);
      check_output("no stray result", bus_i.valid, 1'b0);

      for (int k = 0; k < 10; k++) begin
         ra = $urandom;
         rb = (k % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         rs = 1'($urandom_range(0, 1));
         apply_stimulus(ra, rb, rs, model_of(ra, rb, rs));
         wait_result("random");
      end

      // Async reset in the middle of CALC discards the operation
      apply_stimulus(32'h1234, 32'h0, 1'b0, mk(32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0));
      wait_result("pre-reset");
      apply_stimulus(32'd1000, 32'd3, 1'b0, mk(32'd333, 32'd1, 1'b0, 1'b0));
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("mid reset quo", bus_i.quo, 32'h0);
      check_output("mid reset rem", bus_i.rem, 32'h0);
      check_output("mid reset busy", bus_i.busy, 1'b0);
      check_output("mid reset valid", bus_i.valid, 1'b0);
      check_output("mid reset div_zero", bus_i.div_zero, 1'b0);
      check_output("mid reset ovf", bus_i.ovf, 1'b0);
      sb.delete(sb.size() - 1);
      @(negedge clk);
      rst_n  = 1'b1;
      vcount = 0;
      for (int k = 0; k < LATENCY + 10; k++) begin
         @(negedge clk);
         if (bus_i.valid) vcount++;
      end
      check_output("no valid after reset", vcount, 0);

      apply_stimulus(32'd1000, 32'd3, 1'b0, mk(32'd333, 32'd1, 1'b0, 1'b0));
      wait_result("post reset");

      check_output("scoreboard drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end
endmodule
